// File: rtl/filt_multi.sv
// N-channel glitch filter / debouncer: optional per-channel synchronizer feeding an
// independent 4-state qualification FSM with separate rise and fall counts.
module filt_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RISE_CYC    = 10,
    parameter int FALL_CYC    = 10,
    parameter int CNT_W       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] i,
    output logic [N-1:0] y,
    output logic [N-1:0] rise_pls,
    output logic [N-1:0] fall_pls,
    output logic [N-1:0] glitch_pls
);

    localparam int MAX_CYC = (RISE_CYC > FALL_CYC) ? RISE_CYC : FALL_CYC;
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CYC - 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CYC - 1);

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_PEND_LO = 2'd3
    } state_t;

    generate
        if ((2 ** CNT_W) <= MAX_CYC || N < 1 || SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
            RISE_CYC < 2 || FALL_CYC < 2) begin : g_bad_params
            $error("filt_multi: illegal parameter combination");
        end
    endgenerate

    logic [N-1:0] s;

    // Synchronizer keeps running while en=0 so the FSMs resume on fresh samples.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = i;
        end else begin : g_sync
            logic [N-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= i;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    generate
        for (genvar k = 0; k < N; k++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             y_q, y_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;
            logic             glitch_q, glitch_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q  <= ST_LO;
                    cnt_q    <= '0;
                    y_q      <= 1'b0;
                    rise_q   <= 1'b0;
                    fall_q   <= 1'b0;
                    glitch_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    y_q      <= y_d;
                    rise_q   <= rise_d;
                    fall_q   <= fall_d;
                    glitch_q <= glitch_d;
                end
            end

            // Abort has priority over commit, so glitch never coincides with rise/fall.
            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                y_d      = y_q;
                rise_d   = 1'b0;
                fall_d   = 1'b0;
                glitch_d = 1'b0;
                if (en) begin
                    case (state_q)
                        ST_LO: begin
                            if (s[k]) begin
                                state_d = ST_PEND_HI;
                                cnt_d   = CNT_W'(1);
                            end else begin
                                cnt_d = '0;
                            end
                        end
                        ST_PEND_HI: begin
                            if (!s[k]) begin
                                state_d  = ST_LO;
                                cnt_d    = '0;
                                glitch_d = 1'b1;
                            end else if (cnt_q == RISE_LAST) begin
                                state_d = ST_HI;
                                cnt_d   = '0;
                                y_d     = 1'b1;
                                rise_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        ST_HI: begin
                            if (!s[k]) begin
                                state_d = ST_PEND_LO;
                                cnt_d   = CNT_W'(1);
                            end else begin
                                cnt_d = '0;
                            end
                        end
                        ST_PEND_LO: begin
                            if (s[k]) begin
                                state_d  = ST_HI;
                                cnt_d    = '0;
                                glitch_d = 1'b1;
                            end else if (cnt_q == FALL_LAST) begin
                                state_d = ST_LO;
                                cnt_d   = '0;
                                y_d     = 1'b0;
                                fall_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_d = ST_LO;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            assign y[k]          = y_q;
            assign rise_pls[k]   = rise_q;
            assign fall_pls[k]   = fall_q;
            assign glitch_pls[k] = glitch_q;
        end
    endgenerate

endmodule

// File: tb/tb_filt_multi.sv
// Directed bench for filt_multi: two instances (2-stage and no synchronizer),
// expected output vectors {y,rise,fall,glitch} queued per step and compared after each edge.
module tb_filt_multi;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] i     = 4'd0;

    logic [3:0] ya, ra, fa, ga;
    logic [3:0] yb, rb, fb, gb;

    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    filt_multi #(.N(4), .SYNC_STAGES(2), .RISE_CYC(4), .FALL_CYC(6), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i),
        .y(ya), .rise_pls(ra), .fall_pls(fa), .glitch_pls(ga)
    );

    filt_multi #(.N(4), .SYNC_STAGES(0), .RISE_CYC(4), .FALL_CYC(6), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i),
        .y(yb), .rise_pls(rb), .fall_pls(fb), .glitch_pls(gb)
    );

    function automatic logic [15:0] pk(input logic [3:0] yy, input logic [3:0] rr,
                                       input logic [3:0] ff, input logic [3:0] gg);
        return {yy, rr, ff, gg};
    endfunction

    task automatic compare(input logic sel_b, input string tag);
        logic [15:0] obs;
        logic [15:0] expv;
        obs = sel_b ? {yb, rb, fb, gb} : {ya, ra, fa, ga};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
            end
        end
    endtask

    // Drive one step, let one edge happen, then compare 1 time unit after it.
    task automatic tick(input logic sel_b, input logic e, input logic [3:0] iv,
                        input logic [15:0] expv, input string tag);
        en = e;
        i  = iv;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        compare(sel_b, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        i     = 4'd0;
        #1;
        exp_q.push_back(16'h0);
        compare(1'b0, "rst_a");
        exp_q.push_back(16'h0);
        compare(1'b1, "rst_b");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    initial begin
        int len [4];
        logic [3:0] iv, ey, er, ef, eg;

        // 2-stage sync, RISE=4: commit after edge 5
        do_reset();
        for (int t = 0; t < 7; t++)
            tick(1'b0, 1'b1, 4'b0001,
                 (t == 5) ? pk(4'b0001, 4'b0001, 4'd0, 4'd0) :
                 (t == 6) ? pk(4'b0001, 4'd0, 4'd0, 4'd0) : 16'h0, "t1_sync_rise");

        // Three high samples then low: glitch, no commit
        do_reset();
        for (int t = 0; t < 3; t++) tick(1'b1, 1'b1, 4'b0010, 16'h0, "t2_pend");
        tick(1'b1, 1'b1, 4'b0000, pk(4'd0, 4'd0, 4'd0, 4'b0010), "t2_glitch");
        tick(1'b1, 1'b1, 4'b0000, 16'h0, "t2_after");

        // FALL=6 on channel 2: full fall, then aborted fall
        do_reset();
        for (int t = 0; t < 4; t++)
            tick(1'b1, 1'b1, 4'b0100,
                 (t == 3) ? pk(4'b0100, 4'b0100, 4'd0, 4'd0) : 16'h0, "t3_rise");
        for (int t = 0; t < 6; t++)
            tick(1'b1, 1'b1, 4'b0000,
                 (t == 5) ? pk(4'd0, 4'd0, 4'b0100, 4'd0) : pk(4'b0100, 4'd0, 4'd0, 4'd0),
                 "t3_fall");
        for (int t = 0; t < 4; t++)
            tick(1'b1, 1'b1, 4'b0100,
                 (t == 3) ? pk(4'b0100, 4'b0100, 4'd0, 4'd0) : 16'h0, "t3_rise2");
        for (int t = 0; t < 5; t++)
            tick(1'b1, 1'b1, 4'b0000, pk(4'b0100, 4'd0, 4'd0, 4'd0), "t3_pend_lo");
        tick(1'b1, 1'b1, 4'b0100, pk(4'b0100, 4'd0, 4'd0, 4'b0100), "t3_glitch");
        tick(1'b1, 1'b1, 4'b0100, pk(4'b0100, 4'd0, 4'd0, 4'd0), "t3_hold");

        // en pauses the count without clearing it
        do_reset();
        tick(1'b1, 1'b1, 4'b0001, 16'h0, "t4_en1a");
        tick(1'b1, 1'b0, 4'b0001, 16'h0, "t4_en0a");
        tick(1'b1, 1'b1, 4'b0001, 16'h0, "t4_en1b");
        tick(1'b1, 1'b0, 4'b0001, 16'h0, "t4_en0b");
        tick(1'b1, 1'b1, 4'b0001, 16'h0, "t4_en1c");
        tick(1'b1, 1'b1, 4'b0001, pk(4'b0001, 4'b0001, 4'd0, 4'd0), "t4_commit");
        tick(1'b1, 1'b0, 4'b0000, pk(4'b0001, 4'd0, 4'd0, 4'd0), "t4_en0_hold");
        tick(1'b1, 1'b0, 4'b0000, pk(4'b0001, 4'd0, 4'd0, 4'd0), "t4_en0_hold2");

        // Async reset while ch3 is HI and ch0 is pending
        do_reset();
        for (int t = 0; t < 4; t++)
            tick(1'b1, 1'b1, 4'b1000,
                 (t == 3) ? pk(4'b1000, 4'b1000, 4'd0, 4'd0) : 16'h0, "t5_ch3");
        for (int t = 0; t < 2; t++)
            tick(1'b1, 1'b1, 4'b1001, pk(4'b1000, 4'd0, 4'd0, 4'd0), "t5_pend");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(16'h0);
        compare(1'b1, "t5_async_rst");
        @(posedge clk);
        #1;
        exp_q.push_back(16'h0);
        compare(1'b1, "t5_in_rst");
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++)
            tick(1'b1, 1'b1, 4'b1001,
                 (t == 3) ? pk(4'b1001, 4'b1001, 4'd0, 4'd0) : 16'h0, "t5_requal");

        // All channels at once, high lengths 3/4/5/10
        do_reset();
        len[0] = 3; len[1] = 4; len[2] = 5; len[3] = 10;
        for (int t = 0; t < 17; t++) begin
            iv = 4'd0; ey = 4'd0; er = 4'd0; ef = 4'd0; eg = 4'd0;
            for (int k = 0; k < 4; k++) begin
                iv[k] = (t < len[k]);
                if (k == 0) begin
                    eg[k] = (t == 3);
                end else begin
                    ey[k] = (t >= 3) && (t < len[k] + 5);
                    er[k] = (t == 3);
                    ef[k] = (t == len[k] + 5);
                end
            end
            tick(1'b1, 1'b1, iv, pk(ey, er, ef, eg), "t6_multi");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
